// File: rtl/inst_rom_loader.sv
// Instruction ROM that is filled at run time from a byte stream
// and keeps the CPU in reset until a program has been loaded.
module inst_rom_loader #(
  parameter int ADDR_W = 10
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rom_ce_i,
  input  logic [31:0] rom_addr_i,
  output logic [31:0] rom_data_o,
  output logic        cpu_rst_o,
  input  logic        ld_start_i,
  input  logic        ld_abort_i,
  input  logic        ld_valid_i,
  input  logic [7:0]  ld_byte_i,
  output logic        ld_ready_o,
  output logic        ld_done_o,
  output logic [15:0] words_loaded_o
);

  localparam int DEPTH = 2 ** ADDR_W;

  typedef enum logic [2:0] {
    HOLD, HDR0, HDR1, DATA, RUN
  } state_t;

  state_t      state, state_nxt;
  logic [31:0] mem [DEPTH];
  logic [15:0] count;
  logic [15:0] words;
  logic [1:0]  lane;
  logic [23:0] shreg;
  logic        accept;
  logic        last_byte;
  logic        wr_ok;
  logic        done_nxt;
  logic        hdr_zero;
  logic        upper_hit;
  logic [1:0]  unused_addr_lsb;

  assign accept    = ld_valid_i && ld_ready_o;
  assign last_byte = (state == DATA) && accept && (lane == 2'd3);
  assign wr_ok     = (words >> ADDR_W) == 16'd0;
  assign hdr_zero  = {count[15:8], ld_byte_i} == 16'd0;
  assign unused_addr_lsb = rom_addr_i[1:0];

  always_comb begin
    state_nxt  = state;
    done_nxt   = 1'b0;
    ld_ready_o = 1'b0;
    case (state)
      HOLD, RUN: begin
        if (ld_start_i) state_nxt = HDR0;
      end
      HDR0: begin
        ld_ready_o = 1'b1;
        if (ld_abort_i) state_nxt = HOLD;
        else if (accept) state_nxt = HDR1;
      end
      HDR1: begin
        ld_ready_o = 1'b1;
        if (ld_abort_i) begin
          state_nxt = HOLD;
        end else if (accept) begin
          state_nxt = hdr_zero ? RUN : DATA;
          done_nxt  = hdr_zero;
        end
      end
      DATA: begin
        ld_ready_o = 1'b1;
        if (ld_abort_i) begin
          state_nxt = HOLD;
        end else if (last_byte && (words + 16'd1) == count) begin
          state_nxt = RUN;
          done_nxt  = 1'b1;
        end
      end
      default: state_nxt = HOLD;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= HOLD;
      cpu_rst_o <= 1'b1;
      ld_done_o <= 1'b0;
      words     <= '0;
      count     <= '0;
      lane      <= '0;
      shreg     <= '0;
    end else begin
      state     <= state_nxt;
      cpu_rst_o <= state_nxt != RUN;
      ld_done_o <= done_nxt;
      if ((state == HOLD || state == RUN) && ld_start_i) begin
        words <= '0;
        lane  <= '0;
      end else if (ld_abort_i) begin
        lane <= '0;
      end else if (accept) begin
        case (state)
          HDR0: count[15:8] <= ld_byte_i;
          HDR1: begin
            count[7:0] <= ld_byte_i;
            lane       <= '0;
          end
          DATA: begin
            lane  <= lane + 2'd1;
            shreg <= {shreg[15:0], ld_byte_i};
            if (lane == 2'd3) words <= words + 16'd1;
          end
          default: ;
        endcase
      end
    end
  end

  // No reset: contents survive reset and aborted loads.
  always_ff @(posedge clk) begin
    if (last_byte && !ld_abort_i && wr_ok)
      mem[words[ADDR_W-1:0]] <= {shreg, ld_byte_i};
  end

  assign upper_hit = rom_addr_i[31:ADDR_W+2] != '0;

  always_comb begin
    rom_data_o = '0;
    if (rom_ce_i && !upper_hit && !cpu_rst_o)
      rom_data_o = mem[rom_addr_i[ADDR_W+1:2]];
  end

  assign words_loaded_o = words;

endmodule
